// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipeline_hazard_ctrl.
//   master : datapath side, drives the hazard inputs and receives the stage controls
//   slave  : hazard controller side
// Inputs : id_rs1/id_rs2, id_uses_rs1/id_uses_rs2, exe_mem_read, exe_rd,
//          exe_br_taken, imem_read/imem_resp, dmem_active/dmem_resp
// Outputs: pc_load, if_id_load, id_exe_load, exe_mem_load, mem_wb_load,
//          id_exe_bubble, if_id_flush
interface pipeline_hazard_ctrl_if;
  localparam int unsigned REG_W = 5;

  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             exe_mem_read;
  logic [REG_W-1:0] exe_rd;
  logic             exe_br_taken;
  logic             imem_read;
  logic             imem_resp;
  logic             dmem_active;
  logic             dmem_resp;

  logic             pc_load;
  logic             if_id_load;
  logic             id_exe_load;
  logic             exe_mem_load;
  logic             mem_wb_load;
  logic             id_exe_bubble;
  logic             if_id_flush;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, exe_mem_read, exe_rd,
           exe_br_taken, imem_read, imem_resp, dmem_active, dmem_resp,
    input  pc_load, if_id_load, id_exe_load, exe_mem_load, mem_wb_load,
           id_exe_bubble, if_id_flush
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, exe_mem_read, exe_rd,
           exe_br_taken, imem_read, imem_resp, dmem_active, dmem_resp,
    output pc_load, if_id_load, id_exe_load, exe_mem_load, mem_wb_load,
           id_exe_bubble, if_id_flush
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: freezes on memory stalls, flushes on taken
// branches, inserts a bubble on load-use hazards, and keeps saturating
// performance counters plus a sticky memory-timeout flag.
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   hz (slave)       : hazard inputs and combinational stage controls
//   cnt_clear        : synchronous clear of counters and mem_timeout
//   stall_cnt, bubble_cnt, flush_cnt : saturating event counters
//   mem_timeout      : sticky, a memory stall outlasted TIMEOUT
//   state            : 0 = RUN, 1 = MEM_STALL
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset_n,
  pipeline_hazard_ctrl_if.slave   hz,
  input  logic                    cnt_clear,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        bubble_cnt,
  output logic [CNT_W-1:0]        flush_cnt,
  output logic                    mem_timeout,
  output logic                    state
);

  localparam int unsigned          WAIT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0]    WAIT_MAX = WAIT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]     CNT_MAX  = '1;

  typedef enum logic {
    ST_RUN       = 1'b0,
    ST_MEM_STALL = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_stall;
  logic              load_use;
  logic              flush_ev;
  logic              bubble_ev;
  logic [6:0]        ctl;

  // Hazard detection
  assign mem_stall = (hz.imem_read & ~hz.imem_resp) | (hz.dmem_active & ~hz.dmem_resp);
  assign load_use  = hz.exe_mem_read & (hz.exe_rd != '0) &
                     ((hz.id_uses_rs1 & (hz.exe_rd == hz.id_rs1)) |
                      (hz.id_uses_rs2 & (hz.exe_rd == hz.id_rs2)));

  // Events hidden behind a freeze are not counted; they re-evaluate afterwards
  assign flush_ev  = ~mem_stall & hz.exe_br_taken;
  assign bubble_ev = ~mem_stall & ~hz.exe_br_taken & load_use;

  // Next state, wait counter and stage controls
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    ctl     = '0;

    case (state_q)
      ST_RUN:       if (mem_stall)  state_d = ST_MEM_STALL;
      ST_MEM_STALL: if (!mem_stall) state_d = ST_RUN;
      default:      state_d = ST_RUN;
    endcase

    if (state_d == ST_RUN) begin
      wait_d = '0;
    end else if ((state_q == ST_MEM_STALL) && (wait_q != WAIT_MAX)) begin
      wait_d = wait_q + WAIT_W'(1);
    end

    // Order: pc, if_id, id_exe, exe_mem, mem_wb, id_exe_bubble, if_id_flush
    if (reset_n) begin
      if (mem_stall)             ctl = 7'b000_0000;
      else if (hz.exe_br_taken)  ctl = 7'b111_1111;
      else if (load_use)         ctl = 7'b001_1110;
      else                       ctl = 7'b111_1100;
    end
  end

  assign {hz.pc_load, hz.if_id_load, hz.id_exe_load, hz.exe_mem_load,
          hz.mem_wb_load, hz.id_exe_bubble, hz.if_id_flush} = ctl;

  assign state = (state_q == ST_MEM_STALL);

  // FSM state and stall-duration register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Saturating performance counters and sticky timeout
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt   <= '0;
      bubble_cnt  <= '0;
      flush_cnt   <= '0;
      mem_timeout <= 1'b0;
    end else if (cnt_clear) begin
      stall_cnt   <= '0;
      bubble_cnt  <= '0;
      flush_cnt   <= '0;
      mem_timeout <= 1'b0;
    end else begin
      if (mem_stall && (stall_cnt != CNT_MAX))   stall_cnt  <= stall_cnt + CNT_W'(1);
      if (bubble_ev && (bubble_cnt != CNT_MAX))  bubble_cnt <= bubble_cnt + CNT_W'(1);
      if (flush_ev && (flush_cnt != CNT_MAX))    flush_cnt  <= flush_cnt + CNT_W'(1);
      if ((state_q == ST_MEM_STALL) && (wait_q == WAIT_MAX) && mem_stall) mem_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (CNT_W=2, TIMEOUT=4).
module tb_pipeline_hazard_ctrl;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned TIMEOUT = 4;
  localparam int          CMAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             cnt_clear;
  logic [CNT_W-1:0] stall_cnt, bubble_cnt, flush_cnt;
  logic             mem_timeout;
  logic             state;
  logic [6:0]       ctrl_v;

  int pass_cnt  = 0;
  int total_cnt = 0;

  pipeline_hazard_ctrl_if hif ();

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .hz          (hif),
    .cnt_clear   (cnt_clear),
    .stall_cnt   (stall_cnt),
    .bubble_cnt  (bubble_cnt),
    .flush_cnt   (flush_cnt),
    .mem_timeout (mem_timeout),
    .state       (state)
  );

  always #5 clk = ~clk;

  assign ctrl_v = {hif.pc_load, hif.if_id_load, hif.id_exe_load, hif.exe_mem_load,
                   hif.mem_wb_load, hif.id_exe_bubble, hif.if_id_flush};

  // Reference model: counts of events and length of the current stall run
  int m_stall, m_bubble, m_flush, m_run;
  bit m_timeout;

  function automatic bit f_mem_stall();
    return (hif.imem_read && !hif.imem_resp) || (hif.dmem_active && !hif.dmem_resp);
  endfunction

  function automatic bit f_load_use();
    return hif.exe_mem_read && (hif.exe_rd != 5'd0) &&
           ((hif.id_uses_rs1 && (hif.exe_rd == hif.id_rs1)) ||
            (hif.id_uses_rs2 && (hif.exe_rd == hif.id_rs2)));
  endfunction

  // Expected {pc, if_id, id_exe, exe_mem, mem_wb, bubble, flush}
  function automatic logic [6:0] exp_ctrl();
    if (!reset_n)           return 7'b0000000;
    if (f_mem_stall())      return 7'b0000000;
    if (hif.exe_br_taken)   return 7'b1111111;
    if (f_load_use())       return 7'b0011110;
    return 7'b1111100;
  endfunction

  function automatic int sat(input int v);
    return (v + 1 > CMAX) ? CMAX : v + 1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_stall = 0; m_bubble = 0; m_flush = 0; m_run = 0; m_timeout = 0;
    end else begin
      bit ms, br, lu;
      ms = f_mem_stall();
      br = hif.exe_br_taken;
      lu = f_load_use();
      // The timeout fires once the stall has been seen on TIMEOUT+2 consecutive edges
      m_run = ms ? m_run + 1 : 0;
      if (cnt_clear) begin
        m_stall = 0; m_bubble = 0; m_flush = 0; m_timeout = 0;
      end else begin
        if (ms)              m_stall  = sat(m_stall);
        if (!ms && br)       m_flush  = sat(m_flush);
        if (!ms && !br && lu) m_bubble = sat(m_bubble);
        if (ms && m_run >= int'(TIMEOUT) + 2) m_timeout = 1;
      end
    end
  end

  task automatic idle();
    hif.id_rs1 = 5'd0; hif.id_rs2 = 5'd0;
    hif.id_uses_rs1 = 1'b0; hif.id_uses_rs2 = 1'b0;
    hif.exe_mem_read = 1'b0; hif.exe_rd = 5'd0; hif.exe_br_taken = 1'b0;
    hif.imem_read = 1'b0; hif.imem_resp = 1'b0;
    hif.dmem_active = 1'b0; hif.dmem_resp = 1'b0;
    cnt_clear = 1'b0;
  endtask

  // Advance one clock edge and settle just past it
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counters();
    cnt_clear = 1'b1;
    cycle();
    cnt_clear = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    hif.exe_br_taken = 1'b1;
    #1;
    total_cnt++;
    if (ctrl_v !== 7'b0) $display("FAIL reset_ctrl: got %b expected %b", ctrl_v, 7'b0);
    else pass_cnt++;
    hif.dmem_active = 1'b1;
    cycle();
    total_cnt++;
    if (state !== 1'b0) $display("FAIL reset_state: got %b expected 0", state);
    else pass_cnt++;
    total_cnt++;
    if ({stall_cnt, bubble_cnt, flush_cnt} !== '0) $display("FAIL reset_cnt: got %h expected 0", {stall_cnt, bubble_cnt, flush_cnt});
    else pass_cnt++;
    total_cnt++;
    if (mem_timeout !== 1'b0) $display("FAIL reset_timeout: got %b expected 0", mem_timeout);
    else pass_cnt++;
    idle();
    #2 reset_n = 1'b1;
    #1;
    total_cnt++;
    if (ctrl_v !== 7'b1111100) $display("FAIL reset_release_ctrl: got %b expected %b", ctrl_v, 7'b1111100);
    else pass_cnt++;
    cycle();
  endtask

  task automatic test_load_use();
    clear_counters();
    hif.exe_mem_read = 1'b1; hif.exe_rd = 5'd5; hif.id_rs1 = 5'd5; hif.id_uses_rs1 = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (ctrl_v !== 7'b0011110) $display("FAIL lu_rs1_ctrl: got %b expected %b", ctrl_v, 7'b0011110);
    else pass_cnt++;
    total_cnt++;
    if (bubble_cnt !== 2'd0) $display("FAIL lu_bubble_before: got %0d expected 0", bubble_cnt);
    else pass_cnt++;
    cycle();
    total_cnt++;
    if (bubble_cnt !== 2'd1) $display("FAIL lu_bubble_after: got %0d expected 1", bubble_cnt);
    else pass_cnt++;
    hif.exe_rd = 5'd0; hif.id_rs1 = 5'd0;
    @(negedge clk);
    total_cnt++;
    if (ctrl_v !== 7'b1111100) $display("FAIL lu_x0_ctrl: got %b expected %b", ctrl_v, 7'b1111100);
    else pass_cnt++;
    cycle();
    total_cnt++;
    if (bubble_cnt !== 2'd1) $display("FAIL lu_x0_bubble: got %0d expected 1", bubble_cnt);
    else pass_cnt++;
    // rs2 match counts; an rs1 match that the instruction does not read does not
    hif.exe_rd = 5'd9; hif.id_rs1 = 5'd9; hif.id_uses_rs1 = 1'b0;
    hif.id_rs2 = 5'd9; hif.id_uses_rs2 = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (ctrl_v !== 7'b0011110) $display("FAIL lu_rs2_ctrl: got %b expected %b", ctrl_v, 7'b0011110);
    else pass_cnt++;
    hif.id_uses_rs2 = 1'b0;
    #1;
    total_cnt++;
    if (ctrl_v !== 7'b1111100) $display("FAIL lu_unused_ctrl: got %b expected %b", ctrl_v, 7'b1111100);
    else pass_cnt++;
    cycle();
    idle();
  endtask

  task automatic test_mem_freeze();
    clear_counters();
    hif.dmem_active = 1'b1; hif.dmem_resp = 1'b0;
    hif.exe_mem_read = 1'b1; hif.exe_rd = 5'd5; hif.id_rs1 = 5'd5; hif.id_uses_rs1 = 1'b1;
    hif.exe_br_taken = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({ctrl_v, state} !== 8'b0) $display("FAIL freeze_first: got %b expected 0", {ctrl_v, state});
    else pass_cnt++;
    for (int k = 0; k < 3; k++) cycle();
    @(negedge clk);
    total_cnt++;
    if (ctrl_v !== 7'b0 || state !== 1'b1) $display("FAIL freeze_ctrl_state: got %b/%b expected 0000000/1", ctrl_v, state);
    else pass_cnt++;
    total_cnt++;
    if (stall_cnt !== 2'd3 || bubble_cnt !== 2'd0 || flush_cnt !== 2'd0)
      $display("FAIL freeze_cnts: got s%0d b%0d f%0d expected s3 b0 f0", stall_cnt, bubble_cnt, flush_cnt);
    else pass_cnt++;
    hif.dmem_resp = 1'b1;
    #1;
    total_cnt++;
    if (ctrl_v !== 7'b1111111) $display("FAIL freeze_release_ctrl: got %b expected %b", ctrl_v, 7'b1111111);
    else pass_cnt++;
    cycle();
    total_cnt++;
    if (state !== 1'b0 || flush_cnt !== 2'd1 || bubble_cnt !== 2'd0)
      $display("FAIL freeze_after: got st%b f%0d b%0d expected st0 f1 b0", state, flush_cnt, bubble_cnt);
    else pass_cnt++;
    idle();
    cycle();
  endtask

  task automatic test_timeout();
    clear_counters();
    hif.imem_read = 1'b1; hif.imem_resp = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      if (k == 5) begin
        total_cnt++;
        if (mem_timeout !== 1'b0) $display("FAIL timeout_early: got %b expected 0", mem_timeout);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (mem_timeout !== 1'b1) $display("FAIL timeout_set: got %b expected 1", mem_timeout);
    else pass_cnt++;
    hif.imem_resp = 1'b1;
    cycle();
    cycle();
    total_cnt++;
    if (mem_timeout !== 1'b1 || state !== 1'b0) $display("FAIL timeout_sticky: got to%b st%b expected to1 st0", mem_timeout, state);
    else pass_cnt++;
    clear_counters();
    total_cnt++;
    if (mem_timeout !== 1'b0) $display("FAIL timeout_clear: got %b expected 0", mem_timeout);
    else pass_cnt++;
    idle();
  endtask

  task automatic test_saturate();
    clear_counters();
    hif.exe_br_taken = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cycle();
      total_cnt++;
      if (flush_cnt !== 2'((k > 3) ? 3 : k)) $display("FAIL sat_flush_%0d: got %0d expected %0d", k, flush_cnt, (k > 3) ? 3 : k);
      else pass_cnt++;
    end
    cnt_clear = 1'b1;
    #1;
    total_cnt++;
    if (ctrl_v !== 7'b1111111) $display("FAIL sat_clear_ctrl: got %b expected %b", ctrl_v, 7'b1111111);
    else pass_cnt++;
    cycle();
    total_cnt++;
    if (flush_cnt !== 2'd0) $display("FAIL sat_clear_flush: got %0d expected 0", flush_cnt);
    else pass_cnt++;
    cnt_clear = 1'b0;
    cycle();
    total_cnt++;
    if (flush_cnt !== 2'd1) $display("FAIL sat_restart_flush: got %0d expected 1", flush_cnt);
    else pass_cnt++;
    idle();
  endtask

  task automatic test_reset_mid_stall();
    clear_counters();
    hif.dmem_active = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    total_cnt++;
    if (state !== 1'b1) $display("FAIL rst_mid_pre_state: got %b expected 1", state);
    else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    total_cnt++;
    if (state !== 1'b0 || ctrl_v !== 7'b0 || {stall_cnt, bubble_cnt, flush_cnt, mem_timeout} !== '0)
      $display("FAIL rst_mid_now: got st%b ctl%b s%0d expected st0 ctl0 s0", state, ctrl_v, stall_cnt);
    else pass_cnt++;
    idle();
    #3 reset_n = 1'b1;
    #1;
    total_cnt++;
    if (ctrl_v !== 7'b1111100 || state !== 1'b0) $display("FAIL rst_mid_release: got %b/%b expected 1111100/0", ctrl_v, state);
    else pass_cnt++;
    cycle();
    total_cnt++;
    if (state !== 1'b0 || stall_cnt !== 2'd0) $display("FAIL rst_mid_after: got st%b s%0d expected st0 s0", state, stall_cnt);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int burst = 0;
    for (int i = 0; i < 600; i++) begin
      hif.id_rs1       = 5'($urandom_range(0, 3));
      hif.id_rs2       = 5'($urandom_range(0, 3));
      hif.id_uses_rs1  = 1'($urandom_range(0, 1));
      hif.id_uses_rs2  = 1'($urandom_range(0, 1));
      hif.exe_mem_read = 1'($urandom_range(0, 1));
      hif.exe_rd       = 5'($urandom_range(0, 3));
      hif.exe_br_taken = ($urandom_range(0, 4) == 0);
      hif.dmem_active  = ($urandom_range(0, 5) == 0);
      hif.dmem_resp    = 1'($urandom_range(0, 1));
      cnt_clear        = ($urandom_range(0, 15) == 0);
      if (burst > 0) begin
        burst--;
        hif.imem_read = 1'b1;
        hif.imem_resp = 1'b0;
      end else begin
        if ($urandom_range(0, 19) == 0) burst = $urandom_range(3, 9);
        hif.imem_read = ($urandom_range(0, 3) == 0);
        hif.imem_resp = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      total_cnt++;
      if (ctrl_v !== exp_ctrl()) $display("FAIL rnd_ctrl[%0d]: got %b expected %b", i, ctrl_v, exp_ctrl());
      else pass_cnt++;
      total_cnt++;
      if (state !== (m_run > 0)) $display("FAIL rnd_state[%0d]: got %b expected %b", i, state, m_run > 0);
      else pass_cnt++;
      total_cnt++;
      if (stall_cnt !== 2'(m_stall) || bubble_cnt !== 2'(m_bubble) || flush_cnt !== 2'(m_flush))
        $display("FAIL rnd_cnts[%0d]: got s%0d b%0d f%0d expected s%0d b%0d f%0d",
                 i, stall_cnt, bubble_cnt, flush_cnt, m_stall, m_bubble, m_flush);
      else pass_cnt++;
      total_cnt++;
      if (mem_timeout !== m_timeout) $display("FAIL rnd_timeout[%0d]: got %b expected %b", i, mem_timeout, m_timeout);
      else pass_cnt++;
      cycle();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mem_freeze();
    test_timeout();
    test_saturate();
    test_reset_mid_stall();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of each performance counter.
REQ-002 SHALL have parameter TIMEOUT, default 255: MEM_STALL cycles after which mem_timeout sets.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, named clk and reset_n as elsewhere in the pipeline.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 id_rs1, id_rs2  in  5 each  ID-stage source registers.
REQ-007 id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads that source.
REQ-008 exe_mem_read  in  1  EXE instruction is a load.
REQ-009 exe_rd  in  5  EXE destination register.
REQ-010 exe_br_taken  in  1  EXE resolves a taken branch/jump.
REQ-011 imem_read, imem_resp  in  1 each  fetch request pending / fetch complete.
REQ-012 dmem_active, dmem_resp  in  1 each  MEM-stage access pending / access complete.
REQ-013 cnt_clear  in  1  synchronous clear of counters and mem_timeout.
REQ-014 pc_load, if_id_load, id_exe_load, exe_mem_load, mem_wb_load  out  1 each  stage register enables.
REQ-015 id_exe_bubble  out  1  load NOP into ID/EX instead of ID contents.
REQ-016 if_id_flush  out  1  load NOP into IF/ID.
REQ-017 stall_cnt, bubble_cnt, flush_cnt  out  CNT_W each  saturating event counters.
REQ-018 mem_timeout  out  1  sticky: memory stall exceeded TIMEOUT.
REQ-019 state  out  1  0=RUN, 1=MEM_STALL (debug).

Function
REQ-020 mem_stall SHALL be (imem_read & ~imem_resp) | (dmem_active & ~dmem_resp), combinational.
REQ-021 load_use SHALL be exe_mem_read & exe_rd!=0 & ((id_uses_rs1 & exe_rd==id_rs1) | (id_uses_rs2 & exe_rd==id_rs2)).
REQ-022 Priority SHALL be mem_stall > exe_br_taken > load_use > normal.
REQ-023 mem_stall: all five load outputs 0, id_exe_bubble 0, if_id_flush 0 (full freeze).
REQ-024 exe_br_taken (no mem_stall): all loads 1, if_id_flush 1, id_exe_bubble 1; flush_cnt += 1.
REQ-025 load_use (no mem_stall, no branch): pc_load 0, if_id_load 0, id_exe_load/exe_mem_load/mem_wb_load 1, id_exe_bubble 1; bubble_cnt += 1.
REQ-026 Normal: all loads 1, id_exe_bubble 0, if_id_flush 0.
REQ-027 Control outputs SHALL be combinational from current inputs (zero latency), gated only by reset_n.
REQ-028 FSM: RUN -> MEM_STALL when mem_stall at a clock edge; MEM_STALL -> RUN when mem_stall low at a clock edge; else hold.
REQ-029 Internal wait counter SHALL clear on entering RUN, increment each cycle in MEM_STALL, saturate at TIMEOUT.
REQ-030 mem_timeout SHALL set on the edge where wait counter equals TIMEOUT with mem_stall still high; cleared only by reset or cnt_clear.
REQ-031 stall_cnt SHALL increment each cycle mem_stall is 1.
REQ-032 All counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-033 cnt_clear SHALL zero all counters and mem_timeout at next edge, overriding same-cycle increments; it SHALL NOT alter FSM state or control outputs.
REQ-034 A load_use or branch concurrent with mem_stall SHALL not be counted; it is re-evaluated once the freeze ends.

Reset
REQ-035 reset_n low SHALL immediately force state RUN, wait counter 0, all counters 0, mem_timeout 0.
REQ-036 reset_n low SHALL force all load, bubble and flush outputs to 0 regardless of inputs.
REQ-037 Reset asserted mid-MEM_STALL SHALL abandon the stall; after release the FSM starts in RUN and re-enters MEM_STALL only via REQ-028.

Verification
REQ-038 exe_mem_read=1, exe_rd=5, id_rs1=5, id_uses_rs1=1, no mem stall -> pc_load=0, if_id_load=0, id_exe_bubble=1, bubble_cnt 0->1.
REQ-039 Same as REQ-038 but exe_rd=0 -> normal outputs, bubble_cnt unchanged.
REQ-040 dmem_active=1, dmem_resp=0 for 3 cycles plus load_use and exe_br_taken -> all loads 0, state=1, stall_cnt=3, bubble_cnt/flush_cnt unchanged; dmem_resp=1 -> branch-flush outputs.
REQ-041 TIMEOUT=4, imem_read=1, imem_resp=0 for 6 cycles -> mem_timeout=1 after 5th MEM_STALL edge and stays 1 after stall ends until cnt_clear.
REQ-042 CNT_W=2, exe_br_taken=1 for 5 cycles -> flush_cnt=3 (saturated); cnt_clear with exe_br_taken=1 -> flush_cnt=0.
REQ-043 reset_n low during MEM_STALL -> state=0, counters 0, all loads 0 immediately; release with no stall -> normal outputs.
